// File: rtl/bitset_pkg.sv
// Shared encodings for the bit-set register: command codes and scanner states.
package bitset_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_TOGGLE = 2'b01,
    CMD_LOAD   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bitset_update.sv
// Combinational next-value datapath for the bit vector: per-bit write/toggle
// select, whole-vector load and clear, plus out-of-range index detection.
module bitset_update
  import bitset_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] cur_vec,
  input  logic [1:0]       cmd,
  input  logic [IDX_W-1:0] index,
  input  logic             value,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_vec,
  output logic             index_err
);

  // One bit wider than the index so WIDTH itself is representable.
  localparam logic [IDX_W:0] WIDTH_L = (IDX_W + 1)'(WIDTH);

  logic in_range;

  assign in_range = ({1'b0, index} < WIDTH_L);

  // Only the addressed bit may change on WRITE/TOGGLE; a bad index leaves the vector alone.
  always_comb begin
    next_vec  = cur_vec;
    index_err = 1'b0;
    case (cmd)
      CMD_WRITE, CMD_TOGGLE: begin
        if (in_range) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (index == IDX_W'(i)) begin
              next_vec[i] = (cmd == CMD_WRITE) ? value : ~cur_vec[i];
            end
          end
        end else begin
          index_err = 1'b1;
        end
      end
      CMD_LOAD:  next_vec = load_data;
      CMD_CLEAR: next_vec = '0;
      default:   next_vec = cur_vec;
    endcase
  end

endmodule

// File: rtl/bitset_reg.sv
// WIDTH-bit flag register with single-cycle commands and a sequential,
// wrap-around find-first-set scanner. Commands are blocked while scanning.
module bitset_reg
  import bitset_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic [IDX_W-1:0] index,
  input  logic             value,
  input  logic [WIDTH-1:0] load_data,
  output logic             cmd_ready,
  output logic             cmd_err,
  output logic [WIDTH-1:0] q,
  input  logic             scan_start,
  input  logic [IDX_W-1:0] scan_from,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             scan_found,
  output logic [IDX_W-1:0] scan_index
);

  localparam logic [IDX_W:0]   WIDTH_L  = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;

  logic [WIDTH-1:0] upd_vec;
  logic             upd_err;
  logic             cmd_fire;

  assign cmd_fire = cmd_valid && cmd_ready;

  bitset_update #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_update (
    .cur_vec   (q_q),
    .cmd       (cmd),
    .index     (index),
    .value     (value),
    .load_data (load_data),
    .next_vec  (upd_vec),
    .index_err (upd_err)
  );

  // Accepted commands update the vector; cmd_err is a one-cycle flag for a bad index.
  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (cmd_fire) begin
      q_d   = upd_vec;
      err_d = upd_err;
    end
  end

  // Scanner: one bit examined per cycle, at most WIDTH cycles, results held until next done.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    found_d = found_q;
    sidx_d  = sidx_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_start) begin
          if ({1'b0, scan_from} < WIDTH_L) begin
            state_d = ST_SCAN;
            ptr_d   = scan_from;
            cnt_d   = '0;
          end else begin
            done_d  = 1'b1;
            found_d = 1'b0;
            sidx_d  = '0;
          end
        end
      end
      ST_SCAN: begin
        if (q_q[ptr_q]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          found_d = 1'b1;
          sidx_d  = ptr_q;
        end else if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          found_d = 1'b0;
          sidx_d  = '0;
        end else begin
          ptr_d = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also aborts any scan in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      sidx_q  <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      found_q <= found_d;
      sidx_q  <= sidx_d;
    end
  end

  assign q          = q_q;
  assign cmd_err    = err_q;
  assign scan_busy  = (state_q == ST_SCAN);
  assign cmd_ready  = !scan_busy;
  assign scan_done  = done_q;
  assign scan_found = found_q;
  assign scan_index = sidx_q;

endmodule

// File: tb/tb_bitset_reg.sv
// Bench for bitset_reg at WIDTH=8 and WIDTH=6 with a scan-result scoreboard.
module tb_bitset_reg;
  import bitset_pkg::*;

  typedef struct {
    logic       found;
    logic [2:0] idx;
    int         due;
  } scanExp_t;

  logic clk, reset;
  int   cyc;
  int   checkCount, errorCount;

  logic       c8Valid, c8Value, c8Ready, c8Err;
  logic [1:0] c8Cmd;
  logic [2:0] c8Index, s8From, s8Index;
  logic [7:0] c8Load, q8;
  logic       s8Start, s8Busy, s8Done, s8Found;

  logic       c6Valid, c6Value, c6Ready, c6Err;
  logic [1:0] c6Cmd;
  logic [2:0] c6Index, s6From, s6Index;
  logic [5:0] c6Load, q6;
  logic       s6Start, s6Busy, s6Done, s6Found;

  scanExp_t   sb8[$];
  scanExp_t   sb6[$];
  logic [7:0] qSb8[$];
  logic [5:0] qSb6[$];
  logic [7:0] model8;
  logic [5:0] model6;

  bitset_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .cmd_valid(c8Valid), .cmd(c8Cmd), .index(c8Index),
    .value(c8Value), .load_data(c8Load), .cmd_ready(c8Ready), .cmd_err(c8Err), .q(q8),
    .scan_start(s8Start), .scan_from(s8From), .scan_busy(s8Busy), .scan_done(s8Done),
    .scan_found(s8Found), .scan_index(s8Index)
  );

  bitset_reg #(.WIDTH(6)) dut6 (
    .clk(clk), .reset(reset), .cmd_valid(c6Valid), .cmd(c6Cmd), .index(c6Index),
    .value(c6Value), .load_data(c6Load), .cmd_ready(c6Ready), .cmd_err(c6Err), .q(q6),
    .scan_start(s6Start), .scan_from(s6From), .scan_busy(s6Busy), .scan_done(s6Done),
    .scan_found(s6Found), .scan_index(s6Index)
  );

  // Free-running clock and edge counter used to time scan completion.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference find-first-set with wrap, giving the cycle at which done must be seen.
  function automatic scanExp_t predict(input logic [7:0] vec, input int width, input int from, input int nowCyc);
    scanExp_t e;
    int p;
    e.found = 1'b0;
    e.idx   = 3'd0;
    e.due   = nowCyc + width + 1;
    if (from >= width) begin
      e.due = nowCyc + 1;
      return e;
    end
    for (int k = 0; k < width; k++) begin
      p = (from + k) % width;
      if (vec[p]) begin
        e.found = 1'b1;
        e.idx   = 3'(p);
        e.due   = nowCyc + k + 2;
        return e;
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] applyCmd(input logic [7:0] vec, input int width, input logic [1:0] c,
                                          input int idx, input logic v, input logic [7:0] ld);
    logic [7:0] r;
    r = vec;
    case (c)
      CMD_WRITE:  if (idx < width) r[idx] = v;
      CMD_TOGGLE: if (idx < width) r[idx] = ~vec[idx];
      CMD_LOAD:   r = ld;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic applyStimulus8(input logic [1:0] c, input int idx, input logic v, input logic [7:0] ld, input bit accept);
    logic [7:0] e;
    c8Valid = 1'b1; c8Cmd = c; c8Index = 3'(idx); c8Value = v; c8Load = ld;
    e = accept ? applyCmd(model8, 8, c, idx, v, ld) : model8;
    model8 = e;
    qSb8.push_back(e);
    @(posedge clk); #1;
    c8Valid = 1'b0;
    checkOutput("q8", 32'(q8), 32'(qSb8.pop_front()));
    checkOutput("err8", 32'(c8Err), 32'd0);
  endtask

  task automatic applyStimulus6(input logic [1:0] c, input int idx, input logic v, input logic [5:0] ld, input bit accept);
    logic [7:0] e;
    logic       errExp;
    c6Valid = 1'b1; c6Cmd = c; c6Index = 3'(idx); c6Value = v; c6Load = ld;
    e = accept ? applyCmd({2'b00, model6}, 6, c, idx, v, {2'b00, ld}) : {2'b00, model6};
    errExp = accept && (c == CMD_WRITE || c == CMD_TOGGLE) && (idx >= 6);
    model6 = e[5:0];
    qSb6.push_back(e[5:0]);
    @(posedge clk); #1;
    c6Valid = 1'b0;
    checkOutput("q6", 32'(q6), 32'(qSb6.pop_front()));
    checkOutput("err6", 32'(c6Err), 32'(errExp));
  endtask

  task automatic startScan8(input int from);
    s8Start = 1'b1; s8From = 3'(from);
    sb8.push_back(predict(model8, 8, from, cyc));
    @(posedge clk); #1;
    s8Start = 1'b0;
  endtask

  task automatic startScan6(input int from);
    s6Start = 1'b1; s6From = 3'(from);
    sb6.push_back(predict({2'b00, model6}, 6, from, cyc));
    @(posedge clk); #1;
    s6Start = 1'b0;
  endtask

  // Leaves the caller in the done cycle, just after the falling edge.
  task automatic waitDone8();
    for (int i = 0; i < 40 && sb8.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("scan8_pending", 32'(sb8.size()), 32'd0);
  endtask

  task automatic waitDone6();
    for (int i = 0; i < 40 && sb6.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("scan6_pending", 32'(sb6.size()), 32'd0);
  endtask

  // Scan-result monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    scanExp_t e;
    if (!reset && s8Done) begin
      if (sb8.size() == 0) checkOutput("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = sb8.pop_front();
        checkOutput("found8", 32'(s8Found), 32'(e.found));
        checkOutput("sidx8", 32'(s8Index), 32'(e.idx));
        checkOutput("lat8", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    scanExp_t e;
    if (!reset && s6Done) begin
      if (sb6.size() == 0) checkOutput("done6_unexpected", 32'd1, 32'd0);
      else begin
        e = sb6.pop_front();
        checkOutput("found6", 32'(s6Found), 32'(e.found));
        checkOutput("sidx6", 32'(s6Index), 32'(e.idx));
        checkOutput("lat6", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    checkCount = 0; errorCount = 0;
    reset = 1'b1;
    c8Valid = 0; c8Cmd = 0; c8Index = 0; c8Value = 0; c8Load = 0; s8Start = 0; s8From = 0;
    c6Valid = 0; c6Cmd = 0; c6Index = 0; c6Value = 0; c6Load = 0; s6Start = 0; s6From = 0;
    model8 = 8'h00; model6 = 6'h00;

    @(negedge clk);
    checkOutput("rst_q8", 32'(q8), 32'd0);
    checkOutput("rst_err8", 32'(c8Err), 32'd0);
    checkOutput("rst_busy8", 32'(s8Busy), 32'd0);
    checkOutput("rst_done8", 32'(s8Done), 32'd0);
    checkOutput("rst_found8", 32'(s8Found), 32'd0);
    checkOutput("rst_sidx8", 32'(s8Index), 32'd0);
    checkOutput("rst_ready8", 32'(c8Ready), 32'd1);
    checkOutput("rst_q6", 32'(q6), 32'd0);
    checkOutput("rst_ready6", 32'(c6Ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single-bit write and toggle.
    applyStimulus8(CMD_WRITE, 3, 1'b1, 8'h00, 1);
    applyStimulus8(CMD_TOGGLE, 0, 1'b0, 8'h00, 1);
    checkOutput("q8_0x09", 32'(q8), 32'h09);
    applyStimulus8(CMD_TOGGLE, 0, 1'b0, 8'h00, 1);
    checkOutput("q8_0x08", 32'(q8), 32'h08);

    // Whole-vector load and clear.
    applyStimulus8(CMD_LOAD, 0, 1'b0, 8'hA5, 1);
    applyStimulus8(CMD_CLEAR, 0, 1'b0, 8'h00, 1);

    // Scan with and without wrap; the second start lands in the done cycle.
    applyStimulus8(CMD_LOAD, 0, 1'b0, 8'h40, 1);
    startScan8(3);
    waitDone8();
    startScan8(7);
    checkOutput("b2b_busy8", 32'(s8Busy), 32'd1);
    waitDone8();
    @(posedge clk); #1;
    checkOutput("hold_found8", 32'(s8Found), 32'd1);
    checkOutput("hold_sidx8", 32'(s8Index), 32'd6);

    // Empty vector: full-length scan, a write during it is dropped.
    applyStimulus8(CMD_CLEAR, 0, 1'b0, 8'h00, 1);
    startScan8(0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("busy8", 32'(s8Busy), 32'd1);
      checkOutput("ready8", 32'(c8Ready), 32'd0);
      c8Valid = (i == 2); c8Cmd = CMD_WRITE; c8Index = 3'd0; c8Value = 1'b1;
      @(posedge clk); #1;
    end
    c8Valid = 1'b0;
    checkOutput("busy8_end", 32'(s8Busy), 32'd0);
    checkOutput("dropped_q8", 32'(q8), 32'(model8));
    checkOutput("dropped_err8", 32'(c8Err), 32'd0);
    waitDone8();

    // Non-power-of-two width: bad index, immediate out-of-range scan, wrap.
    @(posedge clk); #1;
    applyStimulus6(CMD_WRITE, 7, 1'b1, 6'h00, 1);
    @(posedge clk); #1;
    checkOutput("err6_pulse", 32'(c6Err), 32'd0);
    applyStimulus6(CMD_WRITE, 5, 1'b1, 6'h00, 1);
    applyStimulus6(CMD_TOGGLE, 1, 1'b0, 6'h00, 1);
    startScan6(6);
    checkOutput("busy6_oor", 32'(s6Busy), 32'd0);
    waitDone6();
    @(posedge clk); #1;
    startScan6(2);
    waitDone6();
    @(posedge clk); #1;
    applyStimulus6(CMD_TOGGLE, 5, 1'b0, 6'h00, 1);
    startScan6(3);
    waitDone6();

    // Reset in the middle of a scan aborts it without a done pulse.
    @(posedge clk); #1;
    startScan8(0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_busy8", 32'(s8Busy), 32'd0);
    checkOutput("rst_mid_ready8", 32'(c8Ready), 32'd1);
    sb8.delete();
    model8 = 8'h00; model6 = 6'h00;
    #4 reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    applyStimulus8(CMD_WRITE, 5, 1'b1, 8'h00, 1);
    startScan8(0);
    waitDone8();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
